// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared cell codes, FSM states and win-line table for the TicTacToe sequencer
package ttt_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_X     = 2'b01;
   localparam logic [1:0] CELL_O     = 2'b10;
   localparam logic [1:0] CELL_HI    = 2'b11;

   typedef enum logic [1:0] {ST_PLAY, ST_CHECK, ST_WIN, ST_DRAW} state_t;

   localparam int         NUM_CELLS = 9;
   localparam int         NUM_LINES = 8;
   localparam logic [3:0] MAX_MOVES = 4'd9;

   // win_mask bit positions; the line table below is keyed by these
   localparam int WM_ROW_TOP  = 0;
   localparam int WM_ROW_MID  = 1;
   localparam int WM_ROW_BOT  = 2;
   localparam int WM_COL_LEFT = 3;
   localparam int WM_COL_MID  = 4;
   localparam int WM_COL_RGT  = 5;
   localparam int WM_DIAG_159 = 6;
   localparam int WM_DIAG_357 = 7;

   // Zero-based cell index (row-major) of member k (0..2) of a line
   function automatic logic [3:0] line_cell(input int line, input int k);
      int c0, c1, c2;
      c0 = 0; c1 = 0; c2 = 0;
      case (line)
         WM_ROW_TOP:  begin c0 = 0; c1 = 1; c2 = 2; end
         WM_ROW_MID:  begin c0 = 3; c1 = 4; c2 = 5; end
         WM_ROW_BOT:  begin c0 = 6; c1 = 7; c2 = 8; end
         WM_COL_LEFT: begin c0 = 0; c1 = 3; c2 = 6; end
         WM_COL_MID:  begin c0 = 1; c1 = 4; c2 = 7; end
         WM_COL_RGT:  begin c0 = 2; c1 = 5; c2 = 8; end
         WM_DIAG_159: begin c0 = 0; c1 = 4; c2 = 8; end
         WM_DIAG_357: begin c0 = 2; c1 = 4; c2 = 6; end
         default:     begin c0 = 0; c1 = 0; c2 = 0; end
      endcase
      if (k == 0)      return 4'(c0);
      else if (k == 1) return 4'(c1);
      else             return 4'(c2);
   endfunction

endpackage

// File: rtl/ttt_line_check.sv
// rtl/ttt_line_check.sv - combinational mask of the lines fully owned by one player
module ttt_line_check
   import ttt_pkg::*;
(
   input  logic [NUM_CELLS-1:0][1:0] board_i,
   input  logic [1:0]                player_i,
   output logic [NUM_LINES-1:0]      line_mask_o
);

   always_comb begin
      line_mask_o = '0;
      for (int l = 0; l < NUM_LINES; l++) begin
         line_mask_o[l] = (board_i[line_cell(l, 0)] == player_i) &&
                          (board_i[line_cell(l, 1)] == player_i) &&
                          (board_i[line_cell(l, 2)] == player_i);
      end
   end

endmodule

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - TicTacToe move sequencer: turn order, legality, win/draw detection
// Optional winning-line blink enabled by defining TTT_WIN_HILITE_EN.
module ttt_game_ctrl
   import ttt_pkg::*;
#(
   parameter logic [1:0] FIRST_PLAYER = 2'b01,
   parameter int         BLINK_DIV    = 12_500_000
) (
   input  logic       clk50M,
   input  logic       reset,
   input  logic       move_valid,
   input  logic [3:0] move_pos,
   output logic       move_ready,
   input  logic       new_game,
   output logic [1:0] position_1,
   output logic [1:0] position_2,
   output logic [1:0] position_3,
   output logic [1:0] position_4,
   output logic [1:0] position_5,
   output logic [1:0] position_6,
   output logic [1:0] position_7,
   output logic [1:0] position_8,
   output logic [1:0] position_9,
   output logic [1:0] turn,
   output logic       illegal_move,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [7:0] win_mask
);

   state_t                   state_q, state_d;
   logic [NUM_CELLS-1:0][1:0] board_q, board_d;
   logic [1:0]               turn_q, turn_d;
   logic [3:0]               count_q, count_d;
   logic [1:0]               winner_q, winner_d;
   logic [NUM_LINES-1:0]     win_mask_q, win_mask_d;
   logic                     illegal_q, illegal_d;
   logic [NUM_LINES-1:0]     line_mask;
   logic [NUM_CELLS-1:0][1:0] disp;

   // turn_q still holds the mover while in CHECK, and the winner while in WIN
   ttt_line_check u_line_check (
      .board_i     (board_q),
      .player_i    (turn_q),
      .line_mask_o (line_mask)
   );

   always_comb begin
      state_d    = state_q;
      board_d    = board_q;
      turn_d     = turn_q;
      count_d    = count_q;
      winner_d   = winner_q;
      win_mask_d = win_mask_q;
      illegal_d  = 1'b0;
      if (new_game) begin
         state_d    = ST_PLAY;
         board_d    = '0;
         turn_d     = FIRST_PLAYER;
         count_d    = '0;
         winner_d   = CELL_EMPTY;
         win_mask_d = '0;
      end else begin
         case (state_q)
            ST_PLAY: begin
               if (move_valid) begin
                  illegal_d = 1'b1;
                  for (int k = 0; k < NUM_CELLS; k++) begin
                     if (move_pos == 4'(k + 1) && board_q[k] == CELL_EMPTY) begin
                        board_d[k] = turn_q;
                        illegal_d  = 1'b0;
                        state_d    = ST_CHECK;
                        count_d    = (count_q == MAX_MOVES) ? count_q : count_q + 4'd1;
                     end
                  end
               end
            end
            ST_CHECK: begin
               if (|line_mask) begin
                  winner_d   = turn_q;
                  win_mask_d = line_mask;
                  state_d    = ST_WIN;
               end else if (count_q == MAX_MOVES) begin
                  state_d = ST_DRAW;
               end else begin
                  turn_d  = (turn_q == CELL_X) ? CELL_O : CELL_X;
                  state_d = ST_PLAY;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk50M) begin
      if (reset) begin
         state_q    <= ST_PLAY;
         board_q    <= '0;
         turn_q     <= FIRST_PLAYER;
         count_q    <= '0;
         winner_q   <= CELL_EMPTY;
         win_mask_q <= '0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         board_q    <= board_d;
         turn_q     <= turn_d;
         count_q    <= count_d;
         winner_q   <= winner_d;
         win_mask_q <= win_mask_d;
         illegal_q  <= illegal_d;
      end
   end

`ifdef TTT_WIN_HILITE_EN
   localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);

   logic [31:0]          blink_cnt_q, blink_cnt_d;
   logic                 blink_q, blink_d;
   logic [NUM_CELLS-1:0] cover;

   // Counting only while staying in WIN keeps the counter at 0 the cycle after leaving
   always_comb begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
      if (state_q == ST_WIN && state_d == ST_WIN) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_d = ~blink_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 32'd1;
            blink_d     = blink_q;
         end
      end
   end

   always_ff @(posedge clk50M) begin
      if (reset) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end

   always_comb begin
      cover = '0;
      for (int l = 0; l < NUM_LINES; l++) begin
         if (win_mask_q[l]) begin
            for (int j = 0; j < 3; j++) cover[line_cell(l, j)] = 1'b1;
         end
      end
   end

   always_comb begin
      disp = board_q;
      for (int k = 0; k < NUM_CELLS; k++) begin
         if (state_q == ST_WIN && blink_q && cover[k]) disp[k] = CELL_HI;
      end
   end
`else
   always_comb begin
      disp = board_q;
   end

   // The blink divider only exists in the highlight build
   if (BLINK_DIV < 1) begin : g_blink_div_unused
   end
`endif

   assign position_1   = disp[0];
   assign position_2   = disp[1];
   assign position_3   = disp[2];
   assign position_4   = disp[3];
   assign position_5   = disp[4];
   assign position_6   = disp[5];
   assign position_7   = disp[6];
   assign position_8   = disp[7];
   assign position_9   = disp[8];
   assign turn         = turn_q;
   assign move_ready   = (state_q == ST_PLAY);
   assign game_over    = (state_q == ST_WIN) || (state_q == ST_DRAW);
   assign illegal_move = illegal_q;
   assign winner       = winner_q;
   assign win_mask     = win_mask_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - directed self-checking bench for ttt_game_ctrl
module tb_ttt_game_ctrl;

   logic       clk50M = 1'b0;
   logic       reset = 1'b1;
   logic       move_valid = 1'b0;
   logic [3:0] move_pos = 4'd0;
   logic       new_game = 1'b0;
   logic       move_ready;
   logic [1:0] position_1, position_2, position_3, position_4, position_5;
   logic [1:0] position_6, position_7, position_8, position_9;
   logic [1:0] turn;
   logic       illegal_move;
   logic       game_over;
   logic [1:0] winner;
   logic [7:0] win_mask;
   logic [17:0] board;

   int pass_cnt = 0;
   int total_cnt = 0;

   ttt_game_ctrl #(.FIRST_PLAYER(2'b01), .BLINK_DIV(4)) dut (
      .clk50M(clk50M), .reset(reset), .move_valid(move_valid), .move_pos(move_pos),
      .move_ready(move_ready), .new_game(new_game),
      .position_1(position_1), .position_2(position_2), .position_3(position_3),
      .position_4(position_4), .position_5(position_5), .position_6(position_6),
      .position_7(position_7), .position_8(position_8), .position_9(position_9),
      .turn(turn), .illegal_move(illegal_move), .game_over(game_over),
      .winner(winner), .win_mask(win_mask)
   );

   always #10 clk50M = ~clk50M;

   assign board = {position_9, position_8, position_7, position_6, position_5,
                   position_4, position_3, position_2, position_1};

   task automatic do_reset();
      @(negedge clk50M) reset = 1'b1;
      @(negedge clk50M) reset = 1'b0;
   endtask

   // Handshake on the posedge after the first negedge; returns two cycles later
   task automatic do_move(input logic [3:0] p);
      @(negedge clk50M) begin move_valid = 1'b1; move_pos = p; end
      @(negedge clk50M) move_valid = 1'b0;
      @(negedge clk50M);
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++; if (board !== 18'h0) $display("FAIL reset_board got %h exp %h", board, 18'h0); else pass_cnt++;
      total_cnt++; if (turn !== 2'b01) $display("FAIL reset_turn got %b exp 01", turn); else pass_cnt++;
      total_cnt++; if (move_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", move_ready); else pass_cnt++;
      total_cnt++; if (illegal_move !== 1'b0) $display("FAIL reset_illegal got %b exp 0", illegal_move); else pass_cnt++;
      total_cnt++; if (game_over !== 1'b0) $display("FAIL reset_game_over got %b exp 0", game_over); else pass_cnt++;
      total_cnt++; if (winner !== 2'b00) $display("FAIL reset_winner got %b exp 00", winner); else pass_cnt++;
      total_cnt++; if (win_mask !== 8'h00) $display("FAIL reset_win_mask got %h exp 00", win_mask); else pass_cnt++;
   endtask

   task automatic test_single_move();
      do_reset();
      @(negedge clk50M) begin move_valid = 1'b1; move_pos = 4'd5; end
      @(negedge clk50M) move_valid = 1'b0;
      total_cnt++; if (position_5 !== 2'b01) $display("FAIL move_pos5 got %b exp 01", position_5); else pass_cnt++;
      total_cnt++; if (move_ready !== 1'b0) $display("FAIL move_ready_low got %b exp 0", move_ready); else pass_cnt++;
      @(negedge clk50M);
      total_cnt++; if (move_ready !== 1'b1) $display("FAIL move_ready_back got %b exp 1", move_ready); else pass_cnt++;
      total_cnt++; if (turn !== 2'b10) $display("FAIL move_turn got %b exp 10", turn); else pass_cnt++;
   endtask

   // Continues from test_single_move: X on 5, O to move
   task automatic test_illegal();
      logic [3:0] bad [3];
      bad[0] = 4'd5; bad[1] = 4'd0; bad[2] = 4'd12;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk50M) begin move_valid = 1'b1; move_pos = bad[i]; end
         @(negedge clk50M) move_valid = 1'b0;
         total_cnt++; if (illegal_move !== 1'b1) $display("FAIL illegal_pulse[%0d] got %b exp 1", i, illegal_move); else pass_cnt++;
         total_cnt++; if (move_ready !== 1'b1) $display("FAIL illegal_ready[%0d] got %b exp 1", i, move_ready); else pass_cnt++;
         @(negedge clk50M);
         total_cnt++; if (illegal_move !== 1'b0) $display("FAIL illegal_one_cycle[%0d] got %b exp 0", i, illegal_move); else pass_cnt++;
         total_cnt++; if (board !== 18'h00100) $display("FAIL illegal_board[%0d] got %h exp 00100", i, board); else pass_cnt++;
         total_cnt++; if (turn !== 2'b10) $display("FAIL illegal_turn[%0d] got %b exp 10", i, turn); else pass_cnt++;
      end
   endtask

   task automatic test_row_win();
      logic [3:0] seq [5];
      seq[0] = 4'd1; seq[1] = 4'd4; seq[2] = 4'd2; seq[3] = 4'd5; seq[4] = 4'd3;
      do_reset();
      for (int i = 0; i < 5; i++) do_move(seq[i]);
      total_cnt++; if (game_over !== 1'b1) $display("FAIL win_game_over got %b exp 1", game_over); else pass_cnt++;
      total_cnt++; if (winner !== 2'b01) $display("FAIL win_winner got %b exp 01", winner); else pass_cnt++;
      total_cnt++; if (win_mask !== 8'h01) $display("FAIL win_mask got %h exp 01", win_mask); else pass_cnt++;
      total_cnt++; if (move_ready !== 1'b0) $display("FAIL win_ready got %b exp 0", move_ready); else pass_cnt++;
      @(negedge clk50M) begin move_valid = 1'b1; move_pos = 4'd9; end
      @(negedge clk50M) move_valid = 1'b0;
      total_cnt++; if (illegal_move !== 1'b0) $display("FAIL win_ignore_illegal got %b exp 0", illegal_move); else pass_cnt++;
      total_cnt++; if (board !== 18'h00295) $display("FAIL win_ignore_board got %h exp 00295", board); else pass_cnt++;
      total_cnt++; if (game_over !== 1'b1) $display("FAIL win_stays_over got %b exp 1", game_over); else pass_cnt++;
      @(negedge clk50M) new_game = 1'b1;
      @(negedge clk50M) new_game = 1'b0;
      total_cnt++; if ({game_over, winner, win_mask, move_ready, board} !== {1'b0, 2'b00, 8'h00, 1'b1, 18'h0})
         $display("FAIL win_new_game got over=%b win=%b mask=%h rdy=%b board=%h exp 0 00 00 1 0",
                  game_over, winner, win_mask, move_ready, board);
      else pass_cnt++;
   endtask

   task automatic test_draw();
      logic [3:0] seq [9];
      seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd3; seq[3] = 4'd5; seq[4] = 4'd4;
      seq[5] = 4'd6; seq[6] = 4'd8; seq[7] = 4'd7; seq[8] = 4'd9;
      do_reset();
      for (int i = 0; i < 9; i++) do_move(seq[i]);
      total_cnt++; if (game_over !== 1'b1) $display("FAIL draw_game_over got %b exp 1", game_over); else pass_cnt++;
      total_cnt++; if (winner !== 2'b00) $display("FAIL draw_winner got %b exp 00", winner); else pass_cnt++;
      total_cnt++; if (win_mask !== 8'h00) $display("FAIL draw_win_mask got %h exp 00", win_mask); else pass_cnt++;
      total_cnt++; if (move_ready !== 1'b0) $display("FAIL draw_ready got %b exp 0", move_ready); else pass_cnt++;
   endtask

   task automatic test_new_game_priority();
      do_reset();
      do_move(4'd5);
      @(negedge clk50M) begin new_game = 1'b1; move_valid = 1'b1; move_pos = 4'd1; end
      @(negedge clk50M) begin new_game = 1'b0; move_valid = 1'b0; end
      total_cnt++; if (board !== 18'h0) $display("FAIL ng_board got %h exp 0", board); else pass_cnt++;
      total_cnt++; if (turn !== 2'b01) $display("FAIL ng_turn got %b exp 01", turn); else pass_cnt++;
      total_cnt++; if (illegal_move !== 1'b0) $display("FAIL ng_illegal got %b exp 0", illegal_move); else pass_cnt++;
      total_cnt++; if (move_ready !== 1'b1) $display("FAIL ng_ready got %b exp 1", move_ready); else pass_cnt++;
      @(negedge clk50M);
      total_cnt++; if (position_1 !== 2'b00) $display("FAIL ng_pos1_later got %b exp 00", position_1); else pass_cnt++;
   endtask

   // X1 O2 X3 O4 X5 O6 X8 O7 X9: X completes 1-5-9 on the ninth move
   task automatic test_diag_win_ninth();
      logic [3:0] seq [9];
      logic [1:0] exp_hot;
      seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd3; seq[3] = 4'd4; seq[4] = 4'd5;
      seq[5] = 4'd6; seq[6] = 4'd8; seq[7] = 4'd7; seq[8] = 4'd9;
      do_reset();
      for (int i = 0; i < 8; i++) do_move(seq[i]);
      total_cnt++; if (game_over !== 1'b0 || turn !== 2'b01)
         $display("FAIL diag_before_last got over=%b turn=%b exp 0 01", game_over, turn);
      else pass_cnt++;
      do_move(seq[8]);
      total_cnt++; if (winner !== 2'b01) $display("FAIL diag_winner got %b exp 01", winner); else pass_cnt++;
      total_cnt++; if (win_mask !== 8'h40) $display("FAIL diag_win_mask got %h exp 40", win_mask); else pass_cnt++;
      for (int c = 0; c < 12; c++) begin
`ifdef TTT_WIN_HILITE_EN
         exp_hot = (((c / 4) % 2) == 1) ? 2'b11 : 2'b01;
`else
         exp_hot = 2'b01;
`endif
         total_cnt++; if ({position_1, position_5, position_9} !== {3{exp_hot}})
            $display("FAIL hilite_cells[%0d] got %b %b %b exp %b", c, position_1, position_5, position_9, exp_hot);
         else pass_cnt++;
         total_cnt++; if ({position_2, position_8} !== {2'b10, 2'b01})
            $display("FAIL hilite_static[%0d] got %b %b exp 10 01", c, position_2, position_8);
         else pass_cnt++;
         @(negedge clk50M);
      end
   endtask

   initial begin
      test_reset();
      test_single_move();
      test_illegal();
      test_row_win();
      test_draw();
      test_new_game_priority();
      test_diag_win_ninth();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
